// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data widths, next-PC select encoding and fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    REDIRECT = 2'b01,
    HALTED   = 2'b10
  } fetch_state_t;

  // An all-zero word decodes as a nop, so it doubles as the bubble pattern.
  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register with flush > pause > load > bubble priority.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_flush,
  input  logic        i_pause,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_npc,
  output logic [31:0] o_instr,
  output logic [31:0] o_npc,
  output logic        o_valid
);

  word_t r_instr;
  word_t r_npc;
  logic  r_valid;

  // Update the IF/ID contents; a bubble keeps npc since it is meaningless when invalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr <= NOP_INSTR;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_npc   <= '0;
      r_valid <= 1'b0;
    end else if (i_pause) begin
      r_instr <= r_instr;
      r_npc   <= r_npc;
      r_valid <= r_valid;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_npc   <= i_npc;
      r_valid <= 1'b1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_npc   = r_npc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, redirect/halt FSM and IF/ID register.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_enable,
  input  logic        flush,
  input  logic        ifid_pause,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  input  logic [31:0] jr_addr,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [4:0]  ifid_rs_out,
  output logic [4:0]  ifid_rt_out
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  word_t        r_pc;
  word_t        w_pc_next;
  word_t        r_redirect;
  word_t        w_redirect_next;
  word_t        w_pc_plus4;
  word_t        w_sel_pc;
  logic         w_ifid_load;
  word_t        w_ifid_instr;

  assign w_pc_plus4 = r_pc + PC_STEP;

  // Select the candidate next PC from the PCsrc encoding.
  always_comb begin
    w_sel_pc = w_pc_plus4;
    case (pcsrc_t'(PCsrc))
      PCSRC_PC4:    w_sel_pc = w_pc_plus4;
      PCSRC_BRANCH: w_sel_pc = branch_addr;
      PCSRC_JUMP:   w_sel_pc = jump_addr;
      PCSRC_JR:     w_sel_pc = jr_addr;
    endcase
  end

  // Next-state logic: a redirect during a miss is parked until the miss resolves; halt wins.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_redirect_next = r_redirect;
    case (r_state)
      FETCH: begin
        if (ihit && pc_enable) begin
          w_pc_next = w_sel_pc;
        end else if (flush && (PCsrc != PCSRC_PC4) && !ihit) begin
          w_redirect_next = w_sel_pc;
          w_state_next    = REDIRECT;
        end
      end
      REDIRECT: begin
        if (ihit) begin
          w_pc_next    = r_redirect;
          w_state_next = FETCH;
        end
      end
      HALTED: begin
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
    if (halt) begin
      w_state_next    = HALTED;
      w_pc_next       = r_pc;
      w_redirect_next = r_redirect;
    end
  end

  // State, PC and parked redirect target registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= FETCH;
      r_pc       <= PC_INIT;
      r_redirect <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_redirect <= w_redirect_next;
    end
  end

  // Only a hit for the PC actually being fetched is a valid instruction.
  assign w_ifid_load = ihit && (r_state == FETCH);

  ifid_latch u_ifid (
    .CLK     (CLK),
    .RST     (RST),
    .i_flush (flush),
    .i_pause (ifid_pause),
    .i_load  (w_ifid_load),
    .i_instr (iload),
    .i_npc   (w_pc_plus4),
    .o_instr (w_ifid_instr),
    .o_npc   (ifid_npc),
    .o_valid (ifid_valid)
  );

  assign ifid_instr  = w_ifid_instr;
  assign ifid_rs_out = w_ifid_instr[25:21];
  assign ifid_rt_out = w_ifid_instr[20:16];
  assign imemaddr    = r_pc;
  assign imemREN     = (r_state != HALTED);

endmodule
